// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a 4-digit hex word by sniffing a multiplexed
// 7-segment display bus (seg/an), with debounce and a valid/ready output.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   seg[6:0]          segment lines, bit0=a .. bit6=g
//   an[3:0]           one-hot digit select, bit0 = rightmost digit
//   hex_word[15:0]    published word, nibble k = digit k
//   word_err[3:0]     per-digit illegal-glyph flag of published word
//   out_valid         hex_word/word_err hold a complete frame
//   out_ready         consumer accepts the frame
//   overrun           sticky: a frame completed while out_valid was high
//
// Parameter STABLE_CYCLES (2..255): cycles a pattern must hold before capture.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode (active-low) pins.

module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] hex_word,
  output logic [3:0]  word_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    COLLECT,
    PUBLISH,
    HOLD
  } state_t;

  // Synchroniser
  logic [6:0] seg_s1_q, seg_s2_q;
  logic [3:0] an_s1_q, an_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      an_s1_q  <= '0;
      an_s2_q  <= '0;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  logic [6:0] seg_v;
  logic [3:0] an_v;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_v = ~seg_s2_q;
  assign an_v  = ~an_s2_q;
`else
  assign seg_v = seg_s2_q;
  assign an_v  = an_s2_q;
`endif

  // Stability counter
  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        fire_q, fire_d;
  logic        onehot;

  assign onehot = (an_v != 4'd0) &&
                  ((an_v & (an_v - 4'd1)) == 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (!onehot) begin
      cnt_d = 8'd0;
    end else if ({an_v, seg_v} != prev_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q < SC) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Rising into saturation marks a capture point; the capture itself
  // happens one cycle later using prev_q, which then holds the stable value.
  assign fire_d = (cnt_d == SC) && (cnt_q != SC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      prev_q <= {an_v, seg_v};
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
    end
  end

  // Glyph decode: {err, nibble}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = 5'h00;
      7'b0000110: decode = 5'h01;
      7'b1011011: decode = 5'h02;
      7'b1001111: decode = 5'h03;
      7'b1100110: decode = 5'h04;
      7'b1101101: decode = 5'h05;
      7'b1111101: decode = 5'h06;
      7'b0000111: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1101111: decode = 5'h09;
      7'b1110111: decode = 5'h0A;
      7'b1111100: decode = 5'h0B;
      7'b0111001: decode = 5'h0C;
      7'b1011110: decode = 5'h0D;
      7'b1111001: decode = 5'h0E;
      7'b1110001: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  logic [3:0] cap_an;
  logic [6:0] cap_seg;
  logic [1:0] cap_idx;
  logic [4:0] cap_dec;

  assign cap_an  = prev_q[10:7];
  assign cap_seg = prev_q[6:0];
  // prev_q an is one-hot whenever fire_q is set
  assign cap_idx = {cap_an[2] | cap_an[3],
                    cap_an[1] | cap_an[3]};
  assign cap_dec = decode(cap_seg);

  // Frame buffer / FSM
  state_t          state_q;
  logic [3:0]      mask_q;
  logic [3:0][3:0] nib_q;
  logic [3:0]      ebuf_q;

  logic       cap_new;
  logic [3:0] cap_bit;
  logic [3:0] mask_cap;
  logic       done;

  always_comb begin
    cap_bit  = 4'd1 << cap_idx;
    cap_new  = fire_q && !mask_q[cap_idx];
    mask_cap = cap_new ? (mask_q | cap_bit) : mask_q;
    done     = cap_new && (mask_cap == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      nib_q     <= '0;
      ebuf_q    <= '0;
      hex_word  <= '0;
      word_err  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // No capture in PUBLISH: the mask is still full there.
      if (cap_new && state_q != PUBLISH) begin
        nib_q[cap_idx]  <= cap_dec[3:0];
        ebuf_q[cap_idx] <= cap_dec[4];
      end
      case (state_q)
        COLLECT: begin
          mask_q <= mask_cap;
          if (done) begin
            state_q <= PUBLISH;
          end
        end
        PUBLISH: begin
          hex_word  <= nib_q;
          word_err  <= ebuf_q;
          out_valid <= 1'b1;
          mask_q    <= '0;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mask_q    <= mask_cap;
            state_q   <= done ? PUBLISH : COLLECT;
          end else if (done) begin
            // Output still owned by consumer: drop this frame.
            overrun <= 1'b1;
            mask_q  <= '0;
          end else begin
            mask_q <= mask_cap;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scan-bus stimulus for seg_scan_decoder
// with a valid/ready scoreboard and directed corner sequences.

module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] hex_word;
  logic [3:0]  word_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  seg_scan_decoder #(.STABLE_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .hex_word  (hex_word),
    .word_err  (word_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  p3, p2, p1, p0;
    logic [15:0] hex;
    logic [3:0]  err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int vcyc  = 0;
  logic [19:0] sbq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change at posedge+1, so at negedge the monitor sees
  // exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) vcyc++;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got %h/%h expected none",
                   hex_word, word_err);
        end else begin
          chk("frame", {12'd0, hex_word, word_err},
              {12'd0, sbq.pop_front()});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic visit(input int k, input logic [6:0] p,
                       input int n);
    an  = 4'(1 << k);
    seg = p;
    tick(n);
  endtask

  task automatic blank(input int n);
    an  = 4'd0;
    seg = 7'd0;
    tick(n);
  endtask

  task automatic scan(input vec_t v);
    visit(3, v.p3, 20);
    visit(2, v.p2, 20);
    visit(1, v.p1, 20);
    visit(0, v.p0, 20);
    blank(6);
  endtask

  vec_t vecs[5];
  vec_t v;
  int   v0;

  initial begin
    vecs[0] = '{7'b1111001, 7'b1011110, 7'b0000110, 7'b0111111,
                16'hED10, 4'b0000};
    vecs[1] = '{7'b1111111, 7'b1101111, 7'b0000001, 7'b1110111,
                16'h890A, 4'b0010};
    vecs[2] = '{7'b0000000, 7'b0000111, 7'b1111100, 7'b1101101,
                16'h07B5, 4'b1000};
    vecs[3] = '{7'b1100110, 7'b1111101, 7'b1001111, 7'b1011011,
                16'h4632, 4'b0000};
    vecs[4] = '{7'b0111001, 7'b1110001, 7'b0000110, 7'b1011011,
                16'hCF12, 4'b0000};

    rst_n     = 1'b0;
    seg       = '0;
    an        = '0;
    out_ready = 1'b1;
    tick(3);
    chk("rst_hex", 32'(hex_word), 32'h0);
    chk("rst_err", 32'(word_err), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_valid", 32'(out_valid), 32'h0);

    for (int i = 0; i < 5; i++) begin
      v0 = vcyc;
      sbq.push_back({vecs[i].hex, vecs[i].err});
      scan(vecs[i]);
      chk($sformatf("drain_%0d", i), sbq.size(), 0);
      chk($sformatf("pulse_%0d", i), vcyc - v0, 1);
    end

    // Digit 2 visits too short to capture
    v = '{7'b1110111, 7'b1111111, 7'b0111001, 7'b1011110,
          16'hA8CD, 4'b0000};
    v0 = vcyc;
    for (int r = 0; r < 2; r++) begin
      visit(3, v.p3, 20);
      visit(2, v.p2, 15);
      visit(1, v.p1, 20);
      visit(0, v.p0, 20);
      blank(6);
    end
    chk("short_nopub", vcyc - v0, 0);
    sbq.push_back({v.hex, v.err});
    visit(2, v.p2, 18);
    blank(6);
    chk("short_pulse", vcyc - v0, 1);
    chk("short_drain", sbq.size(), 0);

    // Backpressure: second frame overruns and is dropped
    out_ready = 1'b0;
    v = '{7'b1011011, 7'b0111111, 7'b1111101, 7'b0000111,
          16'h2067, 4'b0000};
    sbq.push_back({v.hex, v.err});
    scan(v);
    chk("bp_valid1", 32'(out_valid), 32'h1);
    chk("bp_hex1", 32'(hex_word), 32'h2067);
    chk("bp_ovr1", 32'(overrun), 32'h0);
    scan(vecs[3]);
    chk("bp_valid2", 32'(out_valid), 32'h1);
    chk("bp_hex2", 32'(hex_word), 32'h2067);
    chk("bp_ovr2", 32'(overrun), 32'h1);
    out_ready = 1'b1;
    tick(1);
    chk("bp_drop", 32'(out_valid), 32'h0);
    blank(10);
    chk("bp_drain", sbq.size(), 0);
    chk("bp_stay_low", 32'(out_valid), 32'h0);

    // Non-one-hot and zero an must not capture
    v = '{7'b1001111, 7'b0000111, 7'b1101111, 7'b1111001,
          16'h379E, 4'b0000};
    sbq.push_back({v.hex, v.err});
    v0 = vcyc;
    visit(3, v.p3, 20);
    visit(2, v.p2, 20);
    an  = 4'b0011;
    seg = 7'b0000110;
    tick(50);
    an = 4'b0000;
    tick(50);
    chk("junk_nopub", vcyc - v0, 0);
    visit(1, v.p1, 20);
    visit(0, v.p0, 20);
    blank(6);
    chk("junk_pulse", vcyc - v0, 1);
    chk("junk_drain", sbq.size(), 0);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Reset with half a frame captured
    visit(3, 7'b1101101, 20);
    visit(2, 7'b1100110, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_hex", 32'(hex_word), 32'h0);
    chk("mid_err", 32'(word_err), 32'h0);
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_ovr", 32'(overrun), 32'h0);
    blank(2);
    rst_n = 1'b1;
    tick(2);
    v = '{7'b1111100, 7'b1111001, 7'b1011011, 7'b0000110,
          16'hBE21, 4'b0000};
    v0 = vcyc;
    sbq.push_back({v.hex, v.err});
    scan(v);
    chk("post_pulse", vcyc - v0, 1);
    chk("post_drain", sbq.size(), 0);
    chk("post_ovr", 32'(overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
